// File: rtl/hist_shift_search.sv
// hist_shift_search: per-frame AWB histogram alignment engine.
// Sweeps a signed shift of the R and/or B histogram against the fixed G
// histogram. For every shift it sums min(G[k], T[k+s]) over all bins, then
// reports the shift with the largest overlap for each searched channel.
module hist_shift_search #(
    parameter int BINS_LOG2 = 8,
    parameter int CNT_W     = 32,
    parameter int ACC_W     = 40,
    parameter int RD_LAT    = 1,
    parameter int SHIFT_MIN = -64,
    parameter int SHIFT_MAX = 64,
    parameter int STEP      = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [1:0]           i_mode,
    output logic                 o_rd_en,
    output logic [BINS_LOG2-1:0] o_g_addr,
    output logic [BINS_LOG2-1:0] o_r_addr,
    output logic [BINS_LOG2-1:0] o_b_addr,
    input  logic [CNT_W-1:0]     i_g_dout,
    input  logic [CNT_W-1:0]     i_r_dout,
    input  logic [CNT_W-1:0]     i_b_dout,
    output logic                 o_busy,
    output logic                 o_done,
    output logic signed [15:0]   o_r_shift,
    output logic [ACC_W-1:0]     o_r_overlap,
    output logic signed [15:0]   o_b_shift,
    output logic [ACC_W-1:0]     o_b_overlap
);

    localparam int BINS = 1 << BINS_LOG2;
    localparam int DW   = $clog2(RD_LAT + 2);
    localparam logic signed [15:0] SMIN16 = 16'(SHIFT_MIN);

    typedef enum logic [2:0] {IDLE, SWEEP, DRAIN, EVAL, FIN} state_t;

    // Control state
    state_t                 state;
    logic                   both_q;     // R then B requested
    logic                   chan_b;     // channel currently being searched is B
    logic signed [15:0]     s_q;        // current shift
    logic [BINS_LOG2-1:0]   k_q;        // current G bin
    logic [DW-1:0]          drn_q;      // drain cycle counter
    logic [BINS_LOG2-1:0]   tgt_q;      // registered target address
    logic                   inr_q;      // registered in-range flag of the issued read
    logic [RD_LAT-1:0]      vld_p;      // read-valid pipeline
    logic [RD_LAT-1:0]      inr_p;      // in-range pipeline matching vld_p

    // Datapath state
    logic [ACC_W-1:0]       acc;
    logic [ACC_W-1:0]       best;
    logic signed [15:0]     best_shift;

    // Combinational helpers
    logic [CNT_W-1:0]       beat_min;
    logic [CNT_W-1:0]       beat_add;
    logic                   best_win;
    logic [ACC_W-1:0]       best_nx;
    logic signed [15:0]     bshift_nx;
    logic signed [31:0]     s_nx32;
    logic                   more;
    logic                   to_b;
    logic [BINS_LOG2:0]     iss_seq;
    logic [BINS_LOG2:0]     iss_first;
    logic [BINS_LOG2:0]     iss_next;

    // Accumulator add that sticks at all-ones instead of wrapping.
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        logic [ACC_W:0] sum;
        sum = {1'b0, a} + {{(ACC_W + 1 - CNT_W){1'b0}}, b};
        return sum[ACC_W] ? '1 : sum[ACC_W-1:0];
    endfunction

    function automatic logic [CNT_W-1:0] min_cnt(input logic [CNT_W-1:0] a,
                                                 input logic [CNT_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    // Target read for bin k at shift s: {in_range, address}. Out-of-range
    // targets read address 0 and are masked later by the in-range flag.
    function automatic logic [BINS_LOG2:0] issue_rd(input logic [BINS_LOG2-1:0] k,
                                                    input logic signed [15:0] s);
        logic signed [31:0] t;
        t = $signed({{(32 - BINS_LOG2){1'b0}}, k}) + $signed({{16{s[15]}}, s});
        if (t >= 0 && t < BINS) begin
            return {1'b1, t[BINS_LOG2-1:0]};
        end
        return '0;
    endfunction

    assign o_r_addr = tgt_q;
    assign o_b_addr = tgt_q;

    // Beat selection, best-so-far update and next-shift decisions.
    always_comb begin
        beat_min  = min_cnt(i_g_dout, chan_b ? i_b_dout : i_r_dout);
        beat_add  = inr_p[RD_LAT-1] ? beat_min : '0;
        best_win  = acc > best;
        best_nx   = best_win ? acc : best;
        bshift_nx = best_win ? s_q : best_shift;
        s_nx32    = $signed({{16{s_q[15]}}, s_q}) + STEP;
        more      = (s_nx32 <= SHIFT_MAX);
        to_b      = !more && !chan_b && both_q;
        iss_seq   = issue_rd(k_q + 1'b1, s_q);
        iss_first = issue_rd('0, SMIN16);
        iss_next  = issue_rd('0, s_nx32[15:0]);
    end

    // Control FSM with registered read strobes, addresses, status and results.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= IDLE;
            both_q      <= 1'b0;
            chan_b      <= 1'b0;
            s_q         <= '0;
            k_q         <= '0;
            drn_q       <= '0;
            tgt_q       <= '0;
            inr_q       <= 1'b0;
            vld_p       <= '0;
            o_rd_en     <= 1'b0;
            o_g_addr    <= '0;
            o_busy      <= 1'b0;
            o_done      <= 1'b0;
            o_r_shift   <= '0;
            o_r_overlap <= '0;
            o_b_shift   <= '0;
            o_b_overlap <= '0;
        end else begin
            o_done   <= 1'b0;
            vld_p[0] <= o_rd_en;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_p[i] <= vld_p[i-1];
            end
            case (state)
                IDLE: begin
                    if (i_start) begin
                        both_q           <= i_mode[1];
                        chan_b           <= (i_mode == 2'd1);
                        s_q              <= SMIN16;
                        k_q              <= '0;
                        o_g_addr         <= '0;
                        o_rd_en          <= 1'b1;
                        {inr_q, tgt_q}   <= iss_first;
                        o_busy           <= 1'b1;
                        state            <= SWEEP;
                    end
                end
                SWEEP: begin
                    if (&k_q) begin
                        o_rd_en  <= 1'b0;
                        o_g_addr <= '0;
                        tgt_q    <= '0;
                        inr_q    <= 1'b0;
                        drn_q    <= '0;
                        state    <= DRAIN;
                    end else begin
                        k_q            <= k_q + 1'b1;
                        o_g_addr       <= k_q + 1'b1;
                        {inr_q, tgt_q} <= iss_seq;
                    end
                end
                DRAIN: begin
                    if (drn_q == DW'(RD_LAT)) begin
                        state <= EVAL;
                    end else begin
                        drn_q <= drn_q + 1'b1;
                    end
                end
                EVAL: begin
                    if (more) begin
                        s_q            <= s_nx32[15:0];
                        k_q            <= '0;
                        o_g_addr       <= '0;
                        o_rd_en        <= 1'b1;
                        {inr_q, tgt_q} <= iss_next;
                        state          <= SWEEP;
                    end else begin
                        if (chan_b) begin
                            o_b_shift   <= bshift_nx;
                            o_b_overlap <= best_nx;
                        end else begin
                            o_r_shift   <= bshift_nx;
                            o_r_overlap <= best_nx;
                        end
                        if (to_b) begin
                            chan_b         <= 1'b1;
                            s_q            <= SMIN16;
                            k_q            <= '0;
                            o_g_addr       <= '0;
                            o_rd_en        <= 1'b1;
                            {inr_q, tgt_q} <= iss_first;
                            state          <= SWEEP;
                        end else begin
                            o_busy <= 1'b0;
                            o_done <= 1'b1;
                            state  <= FIN;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Overlap accumulation and best-shift tracking; cleared on every new run.
    always_ff @(posedge i_clk) begin
        inr_p[0] <= inr_q;
        for (int i = 1; i < RD_LAT; i++) begin
            inr_p[i] <= inr_p[i-1];
        end
        if (state == IDLE) begin
            acc        <= '0;
            best       <= '0;
            best_shift <= SMIN16;
        end else if (state == EVAL) begin
            acc <= '0;
            if (to_b) begin
                best       <= '0;
                best_shift <= SMIN16;
            end else begin
                best       <= best_nx;
                best_shift <= bshift_nx;
            end
        end else if (vld_p[RD_LAT-1]) begin
            acc <= sat_add(acc, beat_add);
        end
    end

endmodule

// File: tb/tb_hist_shift_search.sv
// Bench for hist_shift_search: small 16-bin configuration with RAM models,
// a reference overlap model feeding a result scoreboard, and a second
// narrow-accumulator instance for saturation.
module tb_hist_shift_search;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (16 bins, shifts -4..4 step 2)
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic               rd_en;
    logic [3:0]         g_addr, r_addr, b_addr;
    logic [31:0]        g_dout = '0, r_dout = '0, b_dout = '0;
    logic               busy, done;
    logic signed [15:0] r_shift, b_shift;
    logic [39:0]        r_ov, b_ov;

    // Saturation instance (8-bit bins and accumulator)
    logic               s_start = 1'b0;
    logic [1:0]         s_mode = 2'd0;
    logic               s_rd_en;
    logic [3:0]         s_g_addr, s_r_addr, s_b_addr;
    logic [7:0]         s_g_dout = '0, s_r_dout = '0, s_b_dout = '0;
    logic               s_busy, s_done;
    logic signed [15:0] s_r_shift, s_b_shift;
    logic [7:0]         s_r_ov, s_b_ov;

    logic [31:0] g_mem [16];
    logic [31:0] r_mem [16];
    logic [31:0] b_mem [16];

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic signed [15:0] rs;
        logic [39:0]        ro;
        logic signed [15:0] bs;
        logic [39:0]        bo;
    } exp_t;
    exp_t sb[$];

    logic signed [15:0] exp_rs = '0, exp_bs = '0;
    logic [39:0]        exp_ro = '0, exp_bo = '0;

    hist_shift_search #(
        .BINS_LOG2(4), .CNT_W(32), .ACC_W(40), .RD_LAT(1),
        .SHIFT_MIN(-4), .SHIFT_MAX(4), .STEP(2)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .i_mode(mode),
        .o_rd_en(rd_en), .o_g_addr(g_addr), .o_r_addr(r_addr), .o_b_addr(b_addr),
        .i_g_dout(g_dout), .i_r_dout(r_dout), .i_b_dout(b_dout),
        .o_busy(busy), .o_done(done),
        .o_r_shift(r_shift), .o_r_overlap(r_ov),
        .o_b_shift(b_shift), .o_b_overlap(b_ov)
    );

    hist_shift_search #(
        .BINS_LOG2(4), .CNT_W(8), .ACC_W(8), .RD_LAT(1),
        .SHIFT_MIN(-4), .SHIFT_MAX(4), .STEP(2)
    ) dut_s (
        .i_clk(clk), .i_rst(rst), .i_start(s_start), .i_mode(s_mode),
        .o_rd_en(s_rd_en), .o_g_addr(s_g_addr), .o_r_addr(s_r_addr), .o_b_addr(s_b_addr),
        .i_g_dout(s_g_dout), .i_r_dout(s_r_dout), .i_b_dout(s_b_dout),
        .o_busy(s_busy), .o_done(s_done),
        .o_r_shift(s_r_shift), .o_r_overlap(s_r_ov),
        .o_b_shift(s_b_shift), .o_b_overlap(s_b_ov)
    );

    // One-cycle-latency histogram RAMs
    always @(posedge clk) begin
        if (rd_en) begin
            g_dout <= g_mem[g_addr];
            r_dout <= r_mem[r_addr];
            b_dout <= b_mem[b_addr];
        end
        if (s_rd_en) begin
            s_g_dout <= 8'd200;
            s_r_dout <= 8'd200;
            s_b_dout <= 8'd200;
        end
    end

    // Scoreboard: compare published results against the oldest expectation
    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: got o_done=1 required no pending run");
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_checks += 4;
                if (r_shift !== e.rs) $display("FAIL sb_r_shift: got %0d required %0d", r_shift, e.rs);
                else n_pass++;
                if (r_ov !== e.ro) $display("FAIL sb_r_overlap: got %0d required %0d", r_ov, e.ro);
                else n_pass++;
                if (b_shift !== e.bs) $display("FAIL sb_b_shift: got %0d required %0d", b_shift, e.bs);
                else n_pass++;
                if (b_ov !== e.bo) $display("FAIL sb_b_overlap: got %0d required %0d", b_ov, e.bo);
                else n_pass++;
            end
        end
    end

    // Reference: exhaustive overlap per shift, strict improvement keeps the
    // most negative shift on ties.
    function automatic void model(input bit use_b, output logic signed [15:0] bsh,
                                  output logic [39:0] bov);
        logic [39:0] ov, gv, tv;
        int t;
        bov = '0;
        bsh = -16'sd4;
        for (int s = -4; s <= 4; s += 2) begin
            ov = '0;
            for (int k = 0; k < 16; k++) begin
                t = k + s;
                if (t >= 0 && t < 16) begin
                    gv = {8'b0, g_mem[k[3:0]]};
                    tv = use_b ? {8'b0, b_mem[t[3:0]]} : {8'b0, r_mem[t[3:0]]};
                    ov += (gv < tv) ? gv : tv;
                end
            end
            if (ov > bov) begin
                bov = ov;
                bsh = 16'(s);
            end
        end
    endfunction

    task automatic launch(input logic [1:0] m);
        exp_t e;
        if (m != 2'd1) model(1'b0, exp_rs, exp_ro);
        if (m != 2'd0) model(1'b1, exp_bs, exp_bo);
        e.rs = exp_rs; e.ro = exp_ro; e.bs = exp_bs; e.bo = exp_bo;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts busy cycles up to the done pulse, then watches for extra pulses.
    task automatic wait_done(output int busy_cnt, output int done_cnt);
        busy_cnt = 0;
        done_cnt = 0;
        for (int c = 0; c < 20000; c++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                break;
            end
            @(negedge clk);
        end
        repeat (5) begin
            @(negedge clk);
            if (done) done_cnt++;
        end
    endtask

    task automatic load_shifted();
        for (int k = 0; k < 16; k++) begin
            g_mem[k] = (k < 8) ? 32'd10 : 32'd0;
            r_mem[k] = (k >= 2 && k < 10) ? 32'd10 : 32'd0;
            b_mem[k] = g_mem[k];
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks += 4;
        if ({rd_en, busy, done} !== 3'b000) $display("FAIL reset_ctrl: got %b required 000", {rd_en, busy, done});
        else n_pass++;
        if ({g_addr, r_addr, b_addr} !== 12'h000) $display("FAIL reset_addr: got %h required 000", {g_addr, r_addr, b_addr});
        else n_pass++;
        if ({r_shift, b_shift} !== 32'h0) $display("FAIL reset_shift: got %h required 0", {r_shift, b_shift});
        else n_pass++;
        if ({r_ov, b_ov} !== 80'h0) $display("FAIL reset_overlap: got %h required 0", {r_ov, b_ov});
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        int bc, dc;
        for (int k = 0; k < 16; k++) begin
            g_mem[k] = '0; r_mem[k] = '0; b_mem[k] = '0;
        end
        launch(2'd0);
        wait_done(bc, dc);
        n_checks += 4;
        if (bc !== 95) $display("FAIL zero_busy: got %0d required 95", bc); else n_pass++;
        if (dc !== 1) $display("FAIL zero_done: got %0d required 1", dc); else n_pass++;
        if (r_shift !== -16'sd4) $display("FAIL zero_r_shift: got %0d required -4", r_shift); else n_pass++;
        if (b_ov !== 40'd0) $display("FAIL zero_b_overlap: got %0d required 0", b_ov); else n_pass++;
    endtask

    task automatic test_identical();
        int bc, dc;
        for (int k = 0; k < 16; k++) begin
            g_mem[k] = 32'(k + 1); r_mem[k] = 32'(k + 1); b_mem[k] = 32'(k + 1);
        end
        launch(2'd2);
        wait_done(bc, dc);
        n_checks += 4;
        if (bc !== 190) $display("FAIL ident_busy: got %0d required 190", bc); else n_pass++;
        if (dc !== 1) $display("FAIL ident_done: got %0d required 1", dc); else n_pass++;
        if (r_ov !== 40'd136 || r_shift !== 16'sd0) $display("FAIL ident_r: got %0d/%0d required 0/136", r_shift, r_ov); else n_pass++;
        if (b_ov !== 40'd136 || b_shift !== 16'sd0) $display("FAIL ident_b: got %0d/%0d required 0/136", b_shift, b_ov); else n_pass++;
    endtask

    task automatic test_shifted();
        int bc, dc;
        load_shifted();
        launch(2'd2);
        wait_done(bc, dc);
        n_checks += 3;
        if (bc !== 190) $display("FAIL shift_busy: got %0d required 190", bc); else n_pass++;
        if (r_ov !== 40'd80 || r_shift !== 16'sd2) $display("FAIL shift_r: got %0d/%0d required 2/80", r_shift, r_ov); else n_pass++;
        if (b_ov !== 40'd80 || b_shift !== 16'sd0) $display("FAIL shift_b: got %0d/%0d required 0/80", b_shift, b_ov); else n_pass++;
    endtask

    task automatic test_persist();
        int bc, dc;
        for (int k = 0; k < 16; k++) b_mem[k] = (k < 6) ? 32'd10 : 32'd0;
        launch(2'd1);
        wait_done(bc, dc);
        n_checks += 3;
        if (bc !== 95) $display("FAIL persist_busy: got %0d required 95", bc); else n_pass++;
        if (b_ov !== 40'd60 || b_shift !== -16'sd2) $display("FAIL persist_b: got %0d/%0d required -2/60", b_shift, b_ov); else n_pass++;
        if (r_ov !== 40'd80 || r_shift !== 16'sd2) $display("FAIL persist_r: got %0d/%0d required 2/80", r_shift, r_ov); else n_pass++;
    endtask

    task automatic test_saturate();
        int bc, dc;
        @(negedge clk);
        s_start = 1'b1;
        s_mode  = 2'd0;
        @(negedge clk);
        s_start = 1'b0;
        bc = 0;
        dc = 0;
        for (int c = 0; c < 2000; c++) begin
            if (s_busy) bc++;
            if (s_done) begin
                dc++;
                break;
            end
            s_start = (c == 10);
            @(negedge clk);
        end
        s_start = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (s_done) dc++;
        end
        n_checks += 4;
        if (bc !== 95) $display("FAIL sat_busy: got %0d required 95", bc); else n_pass++;
        if (dc !== 1) $display("FAIL sat_done: got %0d required 1", dc); else n_pass++;
        if (s_r_ov !== 8'd255 || s_r_shift !== -16'sd4) $display("FAIL sat_r: got %0d/%0d required -4/255", s_r_shift, s_r_ov); else n_pass++;
        if (s_b_ov !== 8'd0 || s_b_shift !== 16'sd0) $display("FAIL sat_b_untouched: got %0d/%0d required 0/0", s_b_shift, s_b_ov); else n_pass++;
    endtask

    task automatic test_mid_reset();
        int bc, dc;
        load_shifted();
        launch(2'd2);
        // Cycle 100 of the run is inside the first B sweep.
        repeat (99) @(negedge clk);
        n_checks++;
        if (rd_en !== 1'b1 || busy !== 1'b1) $display("FAIL midrst_pre: got rd_en=%b busy=%b required 1/1", rd_en, busy);
        else n_pass++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_rs = '0; exp_ro = '0; exp_bs = '0; exp_bo = '0;
        n_checks += 2;
        if ({busy, rd_en, done} !== 3'b000) $display("FAIL midrst_ctrl: got %b required 000", {busy, rd_en, done});
        else n_pass++;
        if ({r_shift, b_shift, r_ov, b_ov} !== 112'h0) $display("FAIL midrst_results: got %h required 0", {r_shift, b_shift, r_ov, b_ov});
        else n_pass++;
        dc = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dc++;
        end
        n_checks++;
        if (dc !== 0) $display("FAIL midrst_no_done: got %0d required 0", dc); else n_pass++;
        launch(2'd2);
        wait_done(bc, dc);
        n_checks += 2;
        if (bc !== 190) $display("FAIL midrst_rerun_busy: got %0d required 190", bc); else n_pass++;
        if (dc !== 1) $display("FAIL midrst_rerun_done: got %0d required 1", dc); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_zero();
        test_identical();
        test_shifted();
        test_persist();
        test_saturate();
        test_mid_reset();
        repeat (3) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) $display("FAIL sb_drained: got %0d pending required 0", sb.size());
        else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/hist_shift_search.md
Name: hist_shift_search

Overview:
Per-frame AWB histogram alignment engine. It runs after the R/G/B histogram RAMs are filled. It sweeps a signed shift of the R and/or B histogram against G, which is the fixed reference. For each shift it accumulates the pairwise overlap sum over k of min(G[k], T[k+s]). It reports, per target channel, the shift with the largest overlap and that overlap value.

Parameters:
BINS_LOG2, 8, log2 of histogram bin count (BINS = 2**BINS_LOG2)
CNT_W, 32, width of one histogram bin count
ACC_W, 40, overlap accumulator width; legal range ACC_W >= CNT_W
RD_LAT, 1, histogram RAM read latency in cycles; legal range >= 1
SHIFT_MIN, -64, first (most negative) shift, signed
SHIFT_MAX, 64, last allowed shift, signed; SHIFT_MIN <= SHIFT_MAX, |SHIFT_*| < BINS
STEP, 4, shift increment; legal range >= 1

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_start  in  1  one-cycle pulse: histograms ready
i_mode  in  2  latched at start: 0 = R only, 1 = B only, 2 or 3 = R then B
o_rd_en  out  1  read strobe, common to all three RAMs
o_g_addr  out  BINS_LOG2  G read address (k)
o_r_addr  out  BINS_LOG2  R read address (k+s, clamped)
o_b_addr  out  BINS_LOG2  B read address (k+s, clamped)
i_g_dout  in  CNT_W  G data, valid RD_LAT cycles after o_rd_en
i_r_dout  in  CNT_W  R data, same timing
i_b_dout  in  CNT_W  B data, same timing
o_busy  out  1  search in progress
o_done  out  1  one-cycle completion pulse
o_r_shift  out  16  best R shift, signed two's complement
o_r_overlap  out  ACC_W  overlap at o_r_shift
o_b_shift  out  16  best B shift, signed
o_b_overlap  out  ACC_W  overlap at o_b_shift

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst is synchronous and active-high.
- Reset: FSM goes to IDLE. All outputs are 0, including o_rd_en, addresses, o_busy and o_done.
- Reset mid-search: abort immediately. No o_done. Result registers are cleared to 0.
- FSM states: IDLE, SWEEP, DRAIN, EVAL, FIN.
- IDLE:
  - i_start moves to SWEEP.
  - i_mode is latched; the first channel is R unless mode = 1.
  - s = SHIFT_MIN, accumulator = 0, best = 0, best_shift = SHIFT_MIN.
  - o_busy rises the cycle after i_start.
- Start while not IDLE: i_start is ignored.
- SWEEP:
  - Lasts BINS cycles, k = 0..BINS-1.
  - o_rd_en = 1.
  - o_g_addr = k.
  - Target address t = k+s, computed signed; other channel's address = same value.
  - If t < 0 or t >= BINS: address is driven 0 and the in-range flag is 0.
  - The in-range flag is pipelined RD_LAT cycles alongside the read.
- Accumulate:
  - On each returning beat, acc += in_range ? min(G, T) : 0, where T is i_r_dout or i_b_dout per the current channel.
  - acc saturates at 2**ACC_W-1 (no wrap).
- DRAIN: lasts RD_LAT+1 cycles with o_rd_en = 0, so the last beat can land in acc.
- EVAL (1 cycle):
  - If acc > best (strict), best = acc and best_shift = s. Ties therefore keep the more negative shift.
  - acc cleared.
  - If s+STEP <= SHIFT_MAX: s += STEP, back to SWEEP.
  - Otherwise the channel is finished: copy best/best_shift to o_r_* or o_b_*.
    - If mode is 2 or 3 and R was just finished: switch to B, reset s/best/best_shift, go to SWEEP.
    - Otherwise go to FIN.
- FIN (1 cycle):
  - o_done = 1, o_busy = 0.
  - Next state IDLE.
- Timing:
  - N = floor((SHIFT_MAX-SHIFT_MIN)/STEP)+1 shifts.
  - C = 1 or 2 channels.
  - o_busy is high for exactly C*N*(BINS+RD_LAT+2) cycles.
  - o_done pulses in the first cycle o_busy is low.
  - Defaults: N=33, 259 cycles per shift, 17094 cycles for both channels.
- Output persistence:
  - A channel not searched in the current run keeps its previous results.
  - Outputs change only at channel finish, never mid-sweep.
- Shift outputs are sign-extended to 16 bits.

Test Plan:
- BINS_LOG2=4, RD_LAT=1, SHIFT -4..4 STEP 2, R=G=B={1..16}, mode=2 -> o_r_shift=0, o_b_shift=0, both overlaps=136; o_busy high exactly 2*5*19=190 cycles; single o_done pulse.
- Same parameters, G[k]=10 for k<8 else 0, R[k+2]=G[k], B=G, mode=2 -> o_r_shift=+2, o_r_overlap=80; o_b_shift=0, o_b_overlap=80.
- All histograms zero, mode=0 -> o_r_shift=-4 (tie rule), o_r_overlap=0; o_b_* remain 0.
- Run mode=2 with the case-2 data, then mode=1 with B[k-2]=G[k] -> o_b_shift=-2, o_b_overlap=60; o_r_* unchanged from the first run (+2/80).
- ACC_W=CNT_W=8, all bins 200, mode=0 -> o_r_overlap=255 (saturated); a second i_start pulsed while o_busy is high is ignored, and cycle count stays 95.
- Assert i_rst mid-SWEEP of B in a mode=2 run -> next cycle: o_busy=0, o_rd_en=0, all results 0, no o_done; a fresh i_start then completes normally.
